// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Selects the writeback value from the MEM/WB register, commits it to the
// register file, and serves two combinational decode read ports with
// same-cycle write-through bypass. After reset a sequential sweep zeroes every
// register; ready stays low until the sweep has finished.
module wb_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic [IDX_W-1:0]  DestReg_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] MemRead_data_in,
  input  logic [IDX_W-1:0]  ReadReg1,
  input  logic [IDX_W-1:0]  ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WB_data_out,
  output logic [IDX_W-1:0]  WB_dest_out,
  output logic              WB_en_out,
  output logic              ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Writeback selection and effective enable are pure functions of MEM/WB.
  assign WB_data_out = MemToReg_in ? MemRead_data_in : ALU_result_in;
  assign WB_dest_out = DestReg_in;
  assign WB_en_out   = RegWrite_in & ready & (DestReg_in != '0);

  // Clear-sweep sequencer: walks clr_idx over every register, then enters RUN.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // clr_idx holds; registers only change through writeback.
        end
        default: begin
          state <= CLEAR;
          clr_idx <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: sweep writes zero during CLEAR, writeback commits in RUN.
  // NOTE: the array has no reset term; the sweep zeroes it one entry per cycle,
  // which keeps it mappable to plain RAM/flops without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (WB_en_out) begin
        regs[DestReg_in] <= WB_data_out;
      end
    end
  end

  // Read port 1: zero register, not-ready, bypass, then storage.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != '0 && ready) begin
      if (WB_en_out && DestReg_in == ReadReg1) begin
        ReadData1 = WB_data_out;
      end else begin
        ReadData1 = regs[ReadReg1];
      end
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != '0 && ready) begin
      if (WB_en_out && DestReg_in == ReadReg2) begin
        ReadData2 = WB_data_out;
      end else begin
        ReadData2 = regs[ReadReg2];
      end
    end
  end

endmodule
